// File: rtl/gate_exerciser.sv
// Stimulus driver and checker for a 2-input gate. It sweeps all four input
// combinations, samples the gate after a settle time and scores it against TRUTH_TABLE.
//
// state | meaning
// IDLE  | drives 00, waits for start
// RUN   | sweeping combinations, sampling gate_result at the end of each settle window
module gate_exerciser #(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [3:0]  TRUTH_TABLE   = 4'b1000,
    parameter int          PASSES        = 1,
    parameter int          ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             gate_result,
    output logic             drive_a,
    output logic             drive_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vector
);

    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [PASS_W-1:0] PASS_LAST   = PASS_W'(PASSES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state, state_next;
    logic [1:0]          combo;
    logic [SET_W-1:0]    settle_cnt;
    logic [PASS_W-1:0]   pass_cnt;
    logic                launch, sample, final_sample, mismatch;

    assign drive_a = combo[1];
    assign drive_b = combo[0];
    assign busy    = (state == RUN);

    always_comb begin
        state_next   = state;
        launch       = 1'b0;
        sample       = 1'b0;
        final_sample = 1'b0;
        mismatch     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    launch     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                // Abort wins over a coinciding sample, which is then discarded.
                if (abort) begin
                    state_next = IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    sample   = 1'b1;
                    mismatch = (gate_result != TRUTH_TABLE[combo]);
                    if (combo == 2'd3 && pass_cnt == PASS_LAST) begin
                        final_sample = 1'b1;
                        state_next   = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            combo       <= '0;
            settle_cnt  <= '0;
            pass_cnt    <= '0;
            err_count   <= '0;
            fail_vector <= '0;
            pass        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= final_sample;
            if (launch) begin
                combo       <= '0;
                settle_cnt  <= '0;
                pass_cnt    <= '0;
                err_count   <= '0;
                fail_vector <= '0;
                pass        <= 1'b0;
            end else if (state == RUN) begin
                if (abort) begin
                    combo      <= '0;
                    settle_cnt <= '0;
                    pass_cnt   <= '0;
                    pass       <= 1'b0;
                end else if (sample) begin
                    settle_cnt <= '0;
                    combo      <= combo + 2'd1;
                    if (combo == 2'd3)
                        pass_cnt <= pass_cnt + 1'b1;
                    if (mismatch) begin
                        fail_vector[combo] <= 1'b1;
                        if (err_count != '1)
                            err_count <= err_count + 1'b1;
                    end
                    // The final sample's own mismatch must count against pass.
                    if (final_sample) begin
                        pass_cnt <= '0;
                        pass     <= (err_count == '0) && !mismatch;
                    end
                end else begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gate_exerciser.sv
// Directed bench for gate_exerciser: four instances cover default AND sweep,
// stuck-at faults, saturation, abort, busy-start, reset and single-cycle settle.
module tb_gate_exerciser;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic st [4];
    logic ab [4];
    logic gr [4];
    logic da [4];
    logic db [4];
    logic bsy [4];
    logic dn [4];
    logic ps [4];
    logic [3:0] fv [4];
    logic [7:0] ec0, ec1, ec3;
    logic [1:0] ec2;
    logic       f1 = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign gr[0] = da[0] & db[0];
    assign gr[1] = f1 | (da[1] & db[1]);
    assign gr[2] = 1'b0;
    assign gr[3] = da[3] & db[3];

    gate_exerciser u0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .abort(ab[0]), .gate_result(gr[0]),
        .drive_a(da[0]), .drive_b(db[0]), .busy(bsy[0]), .done(dn[0]), .pass(ps[0]),
        .err_count(ec0), .fail_vector(fv[0]));

    gate_exerciser #(.PASSES(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .abort(ab[1]), .gate_result(gr[1]),
        .drive_a(da[1]), .drive_b(db[1]), .busy(bsy[1]), .done(dn[1]), .pass(ps[1]),
        .err_count(ec1), .fail_vector(fv[1]));

    gate_exerciser #(.ERR_W(2), .PASSES(3), .TRUTH_TABLE(4'b1111)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .abort(ab[2]), .gate_result(gr[2]),
        .drive_a(da[2]), .drive_b(db[2]), .busy(bsy[2]), .done(dn[2]), .pass(ps[2]),
        .err_count(ec2), .fail_vector(fv[2]));

    gate_exerciser #(.SETTLE_CYCLES(1)) u3 (
        .clk(clk), .rst_n(rst_n), .start(st[3]), .abort(ab[3]), .gate_result(gr[3]),
        .drive_a(da[3]), .drive_b(db[3]), .busy(bsy[3]), .done(dn[3]), .pass(ps[3]),
        .err_count(ec3), .fail_vector(fv[3]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            st[i] = 1'b0;
            ab[i] = 1'b0;
        end

        // reset state
        tick(); tick();
        chk("rst_busy", 32'(bsy[0]), 0);
        chk("rst_done", 32'(dn[0]), 0);
        chk("rst_pass", 32'(ps[0]), 0);
        chk("rst_err", 32'(ec0), 0);
        chk("rst_fv", 32'(fv[0]), 0);
        chk("rst_drive", 32'({da[0], db[0]}), 0);
        rst_n = 1'b1;
        tick();

        // default AND sweep, ideal gate
        st[0] = 1'b1; tick(); st[0] = 1'b0;
        for (int j = 0; j < 8; j++) begin
            chk("t1_drive", 32'({da[0], db[0]}), 32'(j >> 1));
            chk("t1_busy", 32'(bsy[0]), 1);
            chk("t1_done_early", 32'(dn[0]), 0);
            tick();
        end
        chk("t1_done", 32'(dn[0]), 1);
        chk("t1_busy_end", 32'(bsy[0]), 0);
        chk("t1_pass", 32'(ps[0]), 1);
        chk("t1_err", 32'(ec0), 0);
        chk("t1_fv", 32'(fv[0]), 0);
        chk("t1_drive_end", 32'({da[0], db[0]}), 0);
        tick();
        chk("t1_done_pulse", 32'(dn[0]), 0);
        chk("t1_pass_hold", 32'(ps[0]), 1);

        // stuck-at-1, two passes
        f1 = 1'b1;
        st[1] = 1'b1; tick(); st[1] = 1'b0;
        repeat (15) tick();
        chk("t2_done_early", 32'(dn[1]), 0);
        chk("t2_busy", 32'(bsy[1]), 1);
        tick();
        chk("t2_done", 32'(dn[1]), 1);
        chk("t2_err", 32'(ec1), 6);
        chk("t2_fv", 32'(fv[1]), 4'b0111);
        chk("t2_pass", 32'(ps[1]), 0);
        tick();

        // stuck-at-0 vs all-ones table, saturating 2-bit counter
        st[2] = 1'b1; tick(); st[2] = 1'b0;
        repeat (23) tick();
        chk("t3_done_early", 32'(dn[2]), 0);
        tick();
        chk("t3_done", 32'(dn[2]), 1);
        chk("t3_err", 32'(ec2), 3);
        chk("t3_fv", 32'(fv[2]), 4'b1111);
        chk("t3_pass", 32'(ps[2]), 0);
        chk("t3_busy", 32'(bsy[2]), 0);
        chk("t3_drive", 32'({da[2], db[2]}), 0);
        tick();

        // abort during a faulty run; sample coinciding with abort is dropped
        st[1] = 1'b1; tick(); st[1] = 1'b0;
        tick(); tick();
        chk("t4_err_mid", 32'(ec1), 1);
        tick();
        ab[1] = 1'b1; tick(); ab[1] = 1'b0;
        chk("t4_busy", 32'(bsy[1]), 0);
        chk("t4_done", 32'(dn[1]), 0);
        chk("t4_err_hold", 32'(ec1), 1);
        chk("t4_fv_hold", 32'(fv[1]), 4'b0001);
        chk("t4_pass", 32'(ps[1]), 0);
        chk("t4_drive", 32'({da[1], db[1]}), 0);
        for (int j = 0; j < 6; j++) begin
            tick();
            chk("t4_no_done", 32'(dn[1]), 0);
        end
        f1 = 1'b0;
        st[1] = 1'b1; tick(); st[1] = 1'b0;
        chk("t4_err_clr", 32'(ec1), 0);
        chk("t4_fv_clr", 32'(fv[1]), 0);
        repeat (16) tick();
        chk("t4_rerun_done", 32'(dn[1]), 1);
        chk("t4_rerun_pass", 32'(ps[1]), 1);
        chk("t4_rerun_err", 32'(ec1), 0);
        tick();

        // start re-pulsed while busy
        st[0] = 1'b1; tick(); st[0] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            st[0] = (e == 2 || e == 5);
            tick();
            st[0] = 1'b0;
            if (e < 8) chk("t5_no_done", 32'(dn[0]), 0);
        end
        chk("t5_done", 32'(dn[0]), 1);
        tick();
        chk("t5_single_done", 32'(dn[0]), 0);
        chk("t5_idle", 32'(bsy[0]), 0);

        // start and abort together in IDLE, then start held high
        st[0] = 1'b1; ab[0] = 1'b1; tick(); ab[0] = 1'b0;
        chk("t5_abort_wins", 32'(bsy[0]), 0);
        tick();
        chk("t5_held_busy", 32'(bsy[0]), 1);
        repeat (8) tick();
        chk("t5_held_done", 32'(dn[0]), 1);
        chk("t5_held_gap", 32'(bsy[0]), 0);
        tick();
        chk("t5_held_restart", 32'(bsy[0]), 1);
        chk("t5_held_done_off", 32'(dn[0]), 0);
        st[0] = 1'b0;
        ab[0] = 1'b1; tick(); ab[0] = 1'b0;
        chk("t5_abort_run", 32'(bsy[0]), 0);

        // single-cycle settle
        st[3] = 1'b1; tick(); st[3] = 1'b0;
        chk("t6_drive0", 32'({da[3], db[3]}), 0);
        chk("t6_busy", 32'(bsy[3]), 1);
        for (int j = 1; j < 4; j++) begin
            tick();
            chk("t6_drive", 32'({da[3], db[3]}), 32'(j));
        end
        tick();
        chk("t6_done", 32'(dn[3]), 1);
        chk("t6_pass", 32'(ps[3]), 1);
        chk("t6_err", 32'(ec3), 0);
        chk("t6_fv", 32'(fv[3]), 0);
        tick();

        // reset mid-run
        f1 = 1'b1;
        st[1] = 1'b1; tick(); st[1] = 1'b0;
        repeat (4) tick();
        chk("t7_err_mid", 32'(ec1), 2);
        rst_n = 1'b0; tick();
        chk("t7_busy", 32'(bsy[1]), 0);
        chk("t7_done", 32'(dn[1]), 0);
        chk("t7_err", 32'(ec1), 0);
        chk("t7_fv", 32'(fv[1]), 0);
        chk("t7_pass", 32'(ps[1]), 0);
        chk("t7_drive", 32'({da[1], db[1]}), 0);
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("t7_no_done", 32'(dn[1]), 0);
            chk("t7_idle", 32'(bsy[1]), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
